sram_access_arbiter: RTL and testbench

//  Shares the external 1Mx16 SRAM between the SLC-3 CPU memory port (MAR/MDR path) and a debug/loader port.

---
 rtl/sram_arb_pkg.sv | 30 +++
 rtl/sram_access_arbiter_if.sv | 52 +++++
 rtl/sram_arb_pick.sv | 42 ++++
 rtl/sram_access_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the SRAM access arbiter.
//   arb_state_t : arbiter FSM states (idle, strobes active, ack cycle)
//   port_t      : identifies the requesting port (CPU or debug/loader)
//   STROBE_OFF  : inactive level of the active-low SRAM strobes
//   cnt_width() : width of the wait-state down-counter
//   other_port(): the port that is not the given one
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} arb_state_t;

    typedef enum logic {PORT_CPU, PORT_DBG} port_t;

    localparam logic STROBE_OFF = 1'b1;

    // The counter only ever holds W-1 down to 0, so clog2 of the larger
    // wait count is enough, with a floor of one bit.
    function automatic int unsigned cnt_width(input int unsigned rw, input int unsigned ww);
        int unsigned mx;
        mx = (rw > ww) ? rw : ww;
        return (mx <= 1) ? 1 : $clog2(mx);
    endfunction

    function automatic port_t other_port(input port_t p);
        return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_access_arbiter_if
// Bundles the two requester ports and the SRAM-side bus of the arbiter.
//   cpu_* / dbg_*   : req/we/addr/wdata in, ack/rdata out (per port)
//   ADDR            : SRAM address
//   Data_to_SRAM    : write data towards the tristate driver
//   Data_from_SRAM  : read data from the tristate driver
//   CE,UB,LB,OE,WE  : active-low SRAM strobes
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus SRAM/tristate side)
// ----------------------------------------------------------------------------
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              CE, UB, LB, OE, WE;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  Data_from_SRAM,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output ADDR, Data_to_SRAM, CE, UB, LB, OE, WE
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output Data_from_SRAM,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  ADDR, Data_to_SRAM, CE, UB, LB, OE, WE
    );

endinterface

// File: rtl/sram_arb_pick.sv
// ----------------------------------------------------------------------------
// sram_arb_pick
// Combinational grant selection between the CPU and debug ports.
//   rr_ptr_i      : port that wins a tie (only with SRAM_RR_ARB_EN)
//   cpu_req_i     : CPU request
//   dbg_req_i     : debug request
//   grant_valid_o : at least one port is requesting
//   grant_port_o  : winning port
// Configuration macro SRAM_RR_ARB_EN:
//   defined   - ties go to the port named by rr_ptr_i
//   undefined - fixed priority, the CPU wins ties
// ----------------------------------------------------------------------------
import sram_arb_pkg::*;

module sram_arb_pick (
`ifdef SRAM_RR_ARB_EN
    input  port_t rr_ptr_i,
`endif
    input  logic  cpu_req_i,
    input  logic  dbg_req_i,
    output logic  grant_valid_o,
    output port_t grant_port_o
);

    // Pick a winner; a lone requester always wins, only ties consult policy.
    always_comb begin
        grant_valid_o = cpu_req_i | dbg_req_i;
        grant_port_o  = PORT_CPU;
`ifdef SRAM_RR_ARB_EN
        if (cpu_req_i && dbg_req_i) begin
            grant_port_o = rr_ptr_i;
        end else if (dbg_req_i) begin
            grant_port_o = PORT_DBG;
        end
`else
        if (!cpu_req_i && dbg_req_i) begin
            grant_port_o = PORT_DBG;
        end
`endif
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// ----------------------------------------------------------------------------
// sram_access_arbiter
// Shares the external SRAM between the CPU memory port and a debug/loader
// port. Each access becomes IDLE -> ACCESS (W cycles of strobes) -> DONE
// (one-cycle ack), with W = READ_WAIT or WRITE_WAIT.
//   Clk    : system clock
//   Reset  : synchronous, active-high
//   bus    : sram_access_arbiter_if.slave (both ports + SRAM bus)
// All SRAM-side outputs, acks and read data are registered.
// Configuration macro SRAM_RR_ARB_EN selects round-robin arbitration
// (default: fixed priority, CPU first).
// ----------------------------------------------------------------------------
import sram_arb_pkg::*;

module sram_access_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input logic Clk,
    input logic Reset,
    sram_access_arbiter_if.slave bus
);

    localparam int CNT_W = int'(cnt_width(READ_WAIT, WRITE_WAIT));
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_t             port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              wen_q, wen_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef SRAM_RR_ARB_EN
    port_t             rr_ptr_q, rr_ptr_d;
`endif

    logic              grant_valid;
    port_t             grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick u_pick (
`ifdef SRAM_RR_ARB_EN
        .rr_ptr_i      (rr_ptr_q),
`endif
        .cpu_req_i     (bus.cpu_req),
        .dbg_req_i     (bus.dbg_req),
        .grant_valid_o (grant_valid),
        .grant_port_o  (grant_port)
    );

    // Request fields of whichever port is being granted this cycle.
    assign sel_we    = (grant_port == PORT_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign sel_addr  = (grant_port == PORT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = (grant_port == PORT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

    // Next-state and output logic. Strobes are computed one cycle ahead so
    // they come straight out of flops: the grant edge already drives the
    // access strobes, and the last ACCESS edge releases them while raising
    // the ack. Read data is captured on that same edge, while OE is still low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ce_d        = ce_q;
        oe_d        = oe_q;
        wen_d       = wen_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
`ifdef SRAM_RR_ARB_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    port_d  = grant_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ce_d    = 1'b0;
                    oe_d    = sel_we ? STROBE_OFF : 1'b0;
                    wen_d   = sel_we ? 1'b0 : STROBE_OFF;
                    cnt_d   = sel_we ? WRITE_LOAD : READ_LOAD;
                    state_d = S_ACCESS;
`ifdef SRAM_RR_ARB_EN
                    rr_ptr_d = other_port(grant_port);
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    ce_d    = STROBE_OFF;
                    oe_d    = STROBE_OFF;
                    wen_d   = STROBE_OFF;
                    state_d = S_DONE;
                    if (port_q == PORT_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = bus.Data_from_SRAM;
                    end else begin
                        dbg_ack_d = 1'b1;
                        if (!we_q) dbg_rdata_d = bus.Data_from_SRAM;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset returns every strobe to inactive immediately,
    // even in the middle of an access, and suppresses any pending ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            port_q      <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ce_q        <= STROBE_OFF;
            oe_q        <= STROBE_OFF;
            wen_q       <= STROBE_OFF;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef SRAM_RR_ARB_EN
            rr_ptr_q    <= PORT_CPU;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            wen_q       <= wen_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef SRAM_RR_ARB_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Byte lanes are always enabled together with the chip.
    assign bus.ADDR         = addr_q;
    assign bus.Data_to_SRAM = wdata_q;
    assign bus.CE           = ce_q;
    assign bus.UB           = ce_q;
    assign bus.LB           = ce_q;
    assign bus.OE           = oe_q;
    assign bus.WE           = wen_q;
    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.dbg_ack      = dbg_ack_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.dbg_rdata    = dbg_rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_access_arbiter
// Self-checking bench for sram_access_arbiter (READ_WAIT = WRITE_WAIT = 2).
// A small SRAM model answers reads while CE and OE are low and stores on
// every cycle with CE and WE low. Arbitration expectations follow
// SRAM_RR_ARB_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_sram_access_arbiter;

    localparam int W = 2;

    logic clk;
    logic reset;
    int   total    = 0;
    int   passed   = 0;
    int   protoErr = 0;

    logic [15:0] mem [0:255];
    logic        prevCpuAck = 1'b0;
    logic        prevDbgAck = 1'b0;

    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    sram_access_arbiter #(
        .ADDR_W(20), .DATA_W(16), .READ_WAIT(W), .WRITE_WAIT(W)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: drives a poison value when not being read.
    assign bus.Data_from_SRAM = (!bus.CE && !bus.OE) ? mem[bus.ADDR[7:0]] : 16'hDEAD;

    // Memory storage; location 0x12 is preloaded with BEEF during reset.
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h12] <= 16'hBEEF;
        end else if (!bus.CE && !bus.WE) begin
            mem[bus.ADDR[7:0]] <= bus.Data_to_SRAM;
        end
    end

    // Protocol monitor, sampled mid-cycle on every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            protoErr <= protoErr + int'(!bus.OE && !bus.WE) + int'(bus.cpu_ack && bus.dbg_ack)
                        + int'(!bus.WE && bus.CE) + int'(bus.cpu_ack && prevCpuAck)
                        + int'(bus.dbg_ack && prevDbgAck);
            if ((!bus.OE && !bus.WE) || (bus.cpu_ack && bus.dbg_ack) || (!bus.WE && bus.CE)
                || (bus.cpu_ack && prevCpuAck) || (bus.dbg_ack && prevDbgAck))
                $display("[TB] protocol violation at %0t", $time);
        end
        prevCpuAck <= bus.cpu_ack;
        prevDbgAck <= bus.dbg_ack;
    end

    typedef struct {
        logic        isDbg;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic isDbg, input logic we, input logic [19:0] addr,
                                 input logic [15:0] wdata, input logic req);
        if (isDbg) begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    // One access from a negedge; request fields are scrambled after the
    // grant to show the latched copy is used.
    task automatic runAccess(input logic isDbg, input logic we, input logic [19:0] addr,
                             input logic [15:0] wdata, output int lat, output int oeLow,
                             output int weLow, output int badBus, output int otherAck,
                             output logic gotAck);
        lat = 0; oeLow = 0; weLow = 0; badBus = 0; otherAck = 0; gotAck = 1'b0;
        applyStimulus(isDbg, we, addr, wdata, 1'b1);
        while (!gotAck && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) applyStimulus(isDbg, ~we, ~addr, ~wdata, 1'b1);
            if (!bus.OE) oeLow++;
            if (!bus.WE) weLow++;
            if (bus.ADDR !== addr || bus.Data_to_SRAM !== wdata) badBus++;
            if (isDbg ? bus.cpu_ack : bus.dbg_ack) otherAck++;
            gotAck = isDbg ? bus.dbg_ack : bus.cpu_ack;
        end
        applyStimulus(isDbg, we, addr, wdata, 1'b0);
    endtask

    initial begin
        int lat, oeLow, weLow, badBus, otherAck, n, t;
        logic gotAck;
        logic [15:0] expCpuRd, expDbgRd, rd, othRd;
        logic [3:0] order;
        logic [19:0] t5Addr [3];
        logic [15:0] t5Data [3];

        vecs[0] = '{1'b0, 1'b0, 20'h00012, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 20'h0003F, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 20'h0003F, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 20'h00005, 16'hA5A5, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 20'h00005, 16'h5555, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b0, 20'h00012, 16'h0F0F, 16'hBEEF};
        t5Addr[0] = 20'h00012; t5Addr[1] = 20'h00005; t5Addr[2] = 20'h0003F;
        t5Data[0] = 16'hBEEF;  t5Data[1] = 16'hA5A5;  t5Data[2] = 16'h1234;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 20'h0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 20'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_strobes", 32'({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}), 32'h1F);
        checkOutput("rst_addr", 32'(bus.ADDR), 32'h0);
        checkOutput("rst_wdata", 32'(bus.Data_to_SRAM), 32'h0);
        checkOutput("rst_acks", 32'({bus.cpu_ack, bus.dbg_ack}), 32'h0);
        checkOutput("rst_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        expCpuRd = 16'h0;
        expDbgRd = 16'h0;

        // Table-driven single accesses.
        for (int i = 0; i < 6; i++) begin
            runAccess(vecs[i].isDbg, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      lat, oeLow, weLow, badBus, otherAck, gotAck);
            checkOutput($sformatf("v%0d_ack", i), 32'(gotAck), 32'h1);
            checkOutput($sformatf("v%0d_latency", i), lat, W + 1);
            checkOutput($sformatf("v%0d_oe_low", i), oeLow, vecs[i].we ? 0 : W);
            checkOutput($sformatf("v%0d_we_low", i), weLow, vecs[i].we ? W : 0);
            checkOutput($sformatf("v%0d_bus_stable", i), badBus, 0);
            checkOutput($sformatf("v%0d_other_ack", i), otherAck, 0);
            rd    = vecs[i].isDbg ? bus.dbg_rdata : bus.cpu_rdata;
            othRd = vecs[i].isDbg ? bus.cpu_rdata : bus.dbg_rdata;
            if (vecs[i].we) begin
                checkOutput($sformatf("v%0d_mem", i), 32'(mem[vecs[i].addr[7:0]]), 32'(vecs[i].wdata));
            end else begin
                checkOutput($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].expRdata));
                if (vecs[i].isDbg) expDbgRd = vecs[i].expRdata;
                else expCpuRd = vecs[i].expRdata;
            end
            checkOutput($sformatf("v%0d_other_rdata", i), 32'(othRd),
                        32'(vecs[i].isDbg ? expCpuRd : expDbgRd));
            @(negedge clk);
        end

        // Reset in the middle of a write.
        applyStimulus(1'b0, 1'b1, 20'h00080, 16'h7777, 1'b1);
        @(negedge clk);
        checkOutput("t1_we_active", 32'(bus.WE), 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 20'h0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t1_strobes", 32'({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}), 32'h1F);
        checkOutput("t1_addr", 32'(bus.ADDR), 32'h0);
        checkOutput("t1_acks", 32'({bus.cpu_ack, bus.dbg_ack}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dbg_ack || !bus.CE) n++;
        end
        checkOutput("t1_quiet_after", n, 0);

        // Request dropped after the grant still completes.
        applyStimulus(1'b0, 1'b0, 20'h00005, 16'h0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00005, 16'h0, 1'b0);
        t = 1;
        while (!bus.cpu_ack && t < 10) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drop_ack_cycle", t, W + 1);
        checkOutput("drop_rdata", 32'(bus.cpu_rdata), 32'hA5A5);
        @(negedge clk);

        // Contention from a fresh pointer.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00012, 16'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 20'h00012, 16'h0, 1'b1);
        n = 0; t = 0; order = 4'h0;
        while (n < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.cpu_ack) begin order[n] = 1'b0; n++; end
            else if (bus.dbg_ack) begin order[n] = 1'b1; n++; end
        end
        applyStimulus(1'b0, 1'b0, 20'h0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 20'h0, 16'h0, 1'b0);
        checkOutput("t4_ack_count", n, 4);
`ifdef SRAM_RR_ARB_EN
        checkOutput("t4_order", 32'(order), 32'hA);
`else
        checkOutput("t4_order", 32'(order), 32'h0);
`endif
        checkOutput("t4_period", t, 4 * (W + 2) - 1);
        repeat (3) @(negedge clk);

        // Back-to-back reads with the request held high.
        applyStimulus(1'b0, 1'b0, t5Addr[0], 16'h0, 1'b1);
        n = 0; t = 0;
        while (n < 3 && t < 30) begin
            @(negedge clk);
            t++;
            if (t == 1 || t == 5 || t == 9) bus.cpu_addr = 20'hFFFFF;
            if (bus.cpu_ack) begin
                checkOutput($sformatf("t5_ack%0d_cycle", n), t, 3 + 4 * n);
                checkOutput($sformatf("t5_ack%0d_rdata", n), 32'(bus.cpu_rdata), 32'(t5Data[n]));
                checkOutput($sformatf("t5_ack%0d_strobes", n),
                            32'({bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}), 32'h1F);
                n++;
                if (n < 3) bus.cpu_addr = t5Addr[n];
                else bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        checkOutput("t5_ack_count", n, 3);
        repeat (3) @(negedge clk);

        checkOutput("protocol", protoErr, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
